// File: rtl/rv32_alu_pkg.sv
// Shared encodings and helpers for the RV32I execute-stage ALU.
// Operation selects, the alt-bit position and the branch-flag bundle live here.
package rv32_alu_pkg;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam int ALT_BIT = 5;

  typedef struct packed {
    logic eq;
    logic ge;
    logic less;
    logic ge_u;
    logic less_u;
  } flags_t;

  // ge and ge_u are derived from the less-than results so the invariants hold by construction.
  function automatic flags_t cmp_flags(input logic [31:0] a, input logic [31:0] b);
    flags_t f;
    f.eq     = (a == b);
    f.less   = ($signed(a) < $signed(b));
    f.less_u = (a < b);
    f.ge     = ~f.less;
    f.ge_u   = ~f.less_u;
    return f;
  endfunction

endpackage

// File: rtl/rv32_alu_core.sv
// Purely combinational RV32I result mux and branch-compare flags.
// No state; the top registers everything this block produces.
module rv32_alu_core
  import rv32_alu_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [2:0]  funct3_i,
  input  logic        alt_i,
  output logic [31:0] res_o,
  output logic        eq_o,
  output logic        ge_o,
  output logic        less_o,
  output logic        ge_u_o,
  output logic        less_u_o
);

  logic [4:0]  shamt_s;
  logic [31:0] sum_s;
  logic [31:0] diff_s;
  logic [31:0] sra_s;
  flags_t      flags_s;

  assign shamt_s = b_i[4:0];
  assign sum_s   = a_i + b_i;
  assign diff_s  = a_i - b_i;
  assign sra_s   = $unsigned($signed(a_i) >>> shamt_s);
  assign flags_s = cmp_flags(a_i, b_i);

  // Operation select; alt only matters for add/sub and the right shifts.
  always_comb begin
    res_o = 32'h0000_0000;
    case (funct3_i)
      F3_ADD: begin
        if (alt_i) begin
          res_o = diff_s;
        end else begin
          res_o = sum_s;
        end
      end
      F3_SLL:  res_o = a_i << shamt_s;
      F3_SLT:  res_o = {31'b0, flags_s.less};
      F3_SLTU: res_o = {31'b0, flags_s.less_u};
      F3_XOR:  res_o = a_i ^ b_i;
      F3_SR: begin
        if (alt_i) begin
          res_o = sra_s;
        end else begin
          res_o = a_i >> shamt_s;
        end
      end
      F3_OR:   res_o = a_i | b_i;
      F3_AND:  res_o = a_i & b_i;
      default: res_o = 32'h0000_0000;
    endcase
  end

  assign eq_o     = flags_s.eq;
  assign ge_o     = flags_s.ge;
  assign less_o   = flags_s.less;
  assign ge_u_o   = flags_s.ge_u;
  assign less_u_o = flags_s.less_u;

endmodule

// File: rtl/rv32_alu.sv
// Execute-stage RV32I ALU: combinational core plus one output register bank.
// Results and flags appear one edge after their operands; reset clears all outputs.
module rv32_alu
  import rv32_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  output logic [31:0] res1,
  output logic        eq,
  output logic        ge,
  output logic        less,
  output logic        ge_u,
  output logic        less_u
);

  logic [31:0] res_d;
  logic        eq_d;
  logic        ge_d;
  logic        less_d;
  logic        ge_u_d;
  logic        less_u_d;
  logic [31:0] res_q;
  flags_t      flags_q;
  logic        unused_funct7_s;

  // Only the alt bit of funct7 participates in decode.
  assign unused_funct7_s = ^{funct7[6], funct7[4:0]};

  rv32_alu_core u_core (
    .a_i      (a),
    .b_i      (b),
    .funct3_i (funct3),
    .alt_i    (funct7[ALT_BIT]),
    .res_o    (res_d),
    .eq_o     (eq_d),
    .ge_o     (ge_d),
    .less_o   (less_d),
    .ge_u_o   (ge_u_d),
    .less_u_o (less_u_d)
  );

  // Output register bank; the all-zero flag state exists only while in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= 32'h0000_0000;
      flags_q <= '0;
    end else begin
      res_q          <= res_d;
      flags_q.eq     <= eq_d;
      flags_q.ge     <= ge_d;
      flags_q.less   <= less_d;
      flags_q.ge_u   <= ge_u_d;
      flags_q.less_u <= less_u_d;
    end
  end

  assign res1   = res_q;
  assign eq     = flags_q.eq;
  assign ge     = flags_q.ge;
  assign less   = flags_q.less;
  assign ge_u   = flags_q.ge_u;
  assign less_u = flags_q.less_u;

endmodule

// File: tb/tb_rv32_alu.sv
// Directed self-checking bench for rv32_alu with hand-computed vectors.
module tb_rv32_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] res1;
  logic        eq, ge, less, ge_u, less_u;

  int checks;
  int passed;

  rv32_alu dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .funct3 (funct3),
    .funct7 (funct7),
    .res1   (res1),
    .eq     (eq),
    .ge     (ge),
    .less   (less),
    .ge_u   (ge_u),
    .less_u (less_u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Op order: add sub sll slt sltu xor srl sra or and
  logic [2:0] op_f3  [10];
  logic       op_alt [10];
  logic [31:0] va [3];
  logic [31:0] vb [3];
  logic [31:0] vexp [3][10];
  logic [4:0]  vflags [3];   // {eq, ge, less, ge_u, less_u}

  task automatic test_reset();
    rst_n  = 1'b0;
    a      = 32'd20;
    b      = 32'd7;
    funct3 = 3'b000;
    funct7 = 7'h00;
    #3;
    checks++;
    if ({res1, eq, ge, less, ge_u, less_u} !== 37'd0)
      $display("FAIL reset_initial: got res1=%h flags=%b, want 0 and 00000", res1, {eq, ge, less, ge_u, less_u});
    else passed++;
    @(posedge clk); #1;
    checks++;
    if ({res1, eq, ge, less, ge_u, less_u} !== 37'd0)
      $display("FAIL reset_held_over_edge: got res1=%h flags=%b, want 0", res1, {eq, ge, less, ge_u, less_u});
    else passed++;
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (res1 !== 32'd27)
      $display("FAIL reset_first_edge: got res1=%0d, want 27", res1);
    else passed++;
  endtask

  task automatic test_ops();
    op_f3  = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd5, 3'd6, 3'd7};
    op_alt = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    va[0] = 32'd20;        vb[0] = 32'd7;
    va[1] = 32'hFFFFFF9C;  vb[1] = 32'd4;
    va[2] = 32'h00989680;  vb[2] = 32'hFF676980;
    vexp[0] = '{32'd27, 32'd13, 32'd2560, 32'd0, 32'd0, 32'd19, 32'd0, 32'd0, 32'd23, 32'd4};
    vexp[1] = '{32'hFFFFFFA0, 32'hFFFFFF98, 32'hFFFFF9C0, 32'd1, 32'd0,
                32'hFFFFFF98, 32'h0FFFFFF9, 32'hFFFFFFF9, 32'hFFFFFF9C, 32'h4};
    vexp[2] = '{32'h0, 32'h01312D00, 32'h00989680, 32'd0, 32'd1,
                32'hFFFFFF00, 32'h00989680, 32'h00989680, 32'hFFFFFF80, 32'h80};
    vflags[0] = 5'b01010;
    vflags[1] = 5'b00110;
    vflags[2] = 5'b01001;
    for (int v = 0; v < 3; v++) begin
      for (int k = 0; k < 10; k++) begin
        a      = va[v];
        b      = vb[v];
        funct3 = op_f3[k];
        funct7 = {1'b0, op_alt[k], 5'b00000};
        @(posedge clk); #1;
        checks++;
        if (res1 !== vexp[v][k])
          $display("FAIL op_v%0d_k%0d: got res1=%h, want %h", v, k, res1, vexp[v][k]);
        else passed++;
      end
      checks++;
      if ({eq, ge, less, ge_u, less_u} !== vflags[v])
        $display("FAIL flags_v%0d: got %b, want %b", v, {eq, ge, less, ge_u, less_u}, vflags[v]);
      else passed++;
    end
  endtask

  task automatic test_eq_funct7();
    a      = 32'h80000000;
    b      = 32'h80000000;
    funct3 = 3'b000;
    funct7 = 7'h20;
    @(posedge clk); #1;
    checks++;
    if (res1 !== 32'd0 || {eq, ge, less, ge_u, less_u} !== 5'b11010)
      $display("FAIL eq_sub: got res1=%h flags=%b, want 0 and 11010", res1, {eq, ge, less, ge_u, less_u});
    else passed++;
    a      = 32'h0000_00F0;
    b      = 32'h0000_000F;
    funct3 = 3'b110;
    funct7 = 7'h5F;
    @(posedge clk); #1;
    checks++;
    if (res1 !== 32'h0000_00FF)
      $display("FAIL or_funct7_5f: got res1=%h, want 000000ff", res1);
    else passed++;
    funct3 = 3'b111;
    funct7 = 7'h7F;
    @(posedge clk); #1;
    checks++;
    if (res1 !== 32'h0)
      $display("FAIL and_funct7_7f: got res1=%h, want 0", res1);
    else passed++;
    a      = 32'h1;
    b      = 32'hFFFF_FFE3;
    funct3 = 3'b001;
    funct7 = 7'h00;
    @(posedge clk); #1;
    checks++;
    if (res1 !== 32'h8)
      $display("FAIL sll_high_b_ignored: got res1=%h, want 00000008", res1);
    else passed++;
  endtask

  task automatic test_back_to_back();
    a      = 32'd100;
    b      = 32'd1;
    funct3 = 3'b000;
    funct7 = 7'h00;
    @(posedge clk); #1;
    a      = 32'd100;
    b      = 32'd1;
    funct7 = 7'h20;
    #2;
    checks++;
    if (res1 !== 32'd101)
      $display("FAIL latency_hold: got res1=%0d, want 101 before next edge", res1);
    else passed++;
    @(posedge clk); #1;
    checks++;
    if (res1 !== 32'd99)
      $display("FAIL latency_next: got res1=%0d, want 99", res1);
    else passed++;
  endtask

  task automatic test_midreset();
    a      = 32'h0000_0003;
    b      = 32'h0000_0005;
    funct3 = 3'b011;
    funct7 = 7'h00;
    @(posedge clk); #1;
    checks++;
    if (res1 !== 32'd1 || {eq, ge, less, ge_u, less_u} !== 5'b00101)
      $display("FAIL pre_midreset: got res1=%h flags=%b, want 1 and 00101", res1, {eq, ge, less, ge_u, less_u});
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({res1, eq, ge, less, ge_u, less_u} !== 37'd0)
      $display("FAIL midreset_async: got res1=%h flags=%b, want 0", res1, {eq, ge, less, ge_u, less_u});
    else passed++;
    a      = 32'h0000_0009;
    b      = 32'h0000_0009;
    funct3 = 3'b100;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (res1 !== 32'd0 || {eq, ge, less, ge_u, less_u} !== 5'b11010)
      $display("FAIL post_release: got res1=%h flags=%b, want 0 and 11010", res1, {eq, ge, less, ge_u, less_u});
    else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    test_reset();
    test_ops();
    test_eq_funct7();
    test_back_to_back();
    test_midreset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
